bcd_serial_adder: RTL

Parametrised multi-digit packed-BCD adder/subtractor. Processes one decimal digit per clock, least-significant digit first, using a single-digit BCD adder with decimal correction. Uses a start/busy/done handshake. Sits between operand registers and the display path, and replaces the fixed single-digit combinational adder for wide decimal operands.

---
 rtl/bcd_pkg.sv | 40 ++++
 rtl/bcd_digit_adder.sv | 28 ++
 rtl/bcd_serial_adder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
// Provides the digit type, correction constants, FSM states and a seven-segment encoder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Active-high segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seven_seg(input bcd_digit_t d);
        logic [6:0] seg;
        unique case (d)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder/subtractor with decimal correction (combinational).
// Ports: a_i, b_i digits, cin_i carry-in, sub_i selects nine's complement of b_i;
//        digit_o corrected sum digit, cout_o decimal carry-out.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       cin_i,
    input  logic       sub_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    bcd_digit_t b_eff;
    logic [4:0] z;
    logic       corr;

    always_comb begin
        b_eff   = sub_i ? (BCD_MAX - b_i) : b_i;
        z       = {1'b0, a_i} + {1'b0, b_eff} + {4'b0000, cin_i};
        // z > 9 detected on the raw binary sum, including the 4-bit overflow.
        corr    = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
        digit_o = corr ? (z[3:0] + BCD_CORR) : z[3:0];
        cout_o  = corr;
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Ports: clk, rst (sync active-high), start, sub, A, B, Cin in; S, Cout, busy,
//        done, err out. Macro BCD_SERIAL_ADDER_SEG_EN adds HexD seven-segment output.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*N_DIGITS-1:0] A,
    input  logic [4*N_DIGITS-1:0] B,
    input  logic                  Cin,
    output logic [4*N_DIGITS-1:0] S,
    output logic                  Cout,
    output logic                  busy,
    output logic                  done,
`ifdef BCD_SERIAL_ADDER_SEG_EN
    output logic                  err,
    output logic [7*N_DIGITS-1:0] HexD
`else
    output logic                  err
`endif
);

    localparam int W  = 4 * N_DIGITS;
    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, b_q, s_q, s_d;
    logic [CW-1:0]  cnt_q;
    logic           sub_q, c_q, cout_q, done_q, err_q;

    logic           accept, last, bad;
    bcd_digit_t     a_dig, b_dig, dig;
    logic           dig_c;

    assign accept = (state_q != RUN) && start;
    assign last   = (cnt_q == LAST);

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (A[4*i +: 4] > BCD_MAX || B[4*i +: 4] > BCD_MAX)
                bad = 1'b1;
        end
    end

    bcd_digit_adder u_digit (
        .a_i     (a_dig),
        .b_i     (b_dig),
        .cin_i   (c_q),
        .sub_i   (sub_q),
        .digit_o (dig),
        .cout_o  (dig_c)
    );

    // Result digits are written in place as they are produced.
    always_comb begin
        s_d = s_q;
        if (state_q == RUN) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (cnt_q == CW'(i))
                    s_d[4*i +: 4] = dig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (last)  state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            cnt_q  <= '0;
            sub_q  <= 1'b0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                sub_q <= sub;
                c_q   <= sub | Cin;
                cnt_q <= '0;
                err_q <= bad;
            end else if (state_q == RUN) begin
                s_q   <= s_d;
                c_q   <= dig_c;
                cnt_q <= cnt_q + 1'b1;
                if (last) begin
                    cout_q <= dig_c;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        S    = s_q;
        Cout = cout_q;
        err  = err_q;
    end

`ifdef BCD_SERIAL_ADDER_SEG_EN
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_seg
        assign HexD[7*g +: 7] = seven_seg(s_q[4*g +: 4]);
    end
`endif

endmodule
